// File: rtl/intt_core.sv
//------------------------------------------------------------------------------
// intt_core : sequential Kyber inverse NTT. One Gentleman-Sande butterfly per cycle.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module intt_core #(
  parameter int Q     = 3329,
  parameter int N     = 256,
  parameter int N_INV = 3303
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2047:0] i_zetas,
  input  logic [15:0]   i_in_data,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  output logic [15:0]   o_out_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic          o_busy
);

  localparam int       c_BARRETT_K = 26;
  localparam int       c_BARRETT_M = (1 << c_BARRETT_K) / Q;
  localparam bit [7:0] c_LAST_IDX  = 8'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_mem [0:255];
  logic [7:0]  r_idx;
  logic [6:0]  r_bf;
  logic [2:0]  r_layer;
  logic [6:0]  r_k;
  logic [11:0] r_out_data;
  logic        r_out_valid;

  // Barrett estimate may undershoot the quotient by one; two trims make it exact.
  function automatic logic [11:0] f_reduce(input logic [25:0] x);
    logic [41:0] w_prod;
    logic [15:0] w_qe;
    logic [27:0] w_r;
    w_prod = 42'(x) * 42'(c_BARRETT_M);
    w_qe   = 16'(w_prod >> c_BARRETT_K);
    w_r    = 28'(x) - 28'(w_qe) * 28'(Q);
    if (w_r >= 28'(Q)) w_r = w_r - 28'(Q);
    if (w_r >= 28'(Q)) w_r = w_r - 28'(Q);
    return 12'(w_r);
  endfunction

  logic        w_load_xfer, w_out_xfer, w_cmp_last, w_blk_end;
  logic [7:0]  w_len, w_mask, w_bf8, w_j, w_jl, w_oaddr;
  logic [11:0] w_a, w_b, w_zeta, w_sum_red, w_bf_red, w_out_red;
  logic [12:0] w_sum, w_diff;
  logic [25:0] w_bf_prod, w_out_prod;

  assign w_load_xfer = (r_state == S_LOAD) && i_in_valid;
  assign w_out_xfer  = (r_state == S_OUT) && r_out_valid && i_out_ready;
  assign w_cmp_last  = (r_layer == 3'd6) && (r_bf == 7'd127);

  // Butterfly index j: insert a zero bit at position log2(len) of the counter.
  assign w_len     = 8'd2 << r_layer;
  assign w_mask    = w_len - 8'd1;
  assign w_bf8     = {1'b0, r_bf};
  assign w_j       = (w_bf8 & w_mask) | ((w_bf8 & ~w_mask) << 1);
  assign w_jl      = w_j + w_len;
  assign w_blk_end = (w_bf8 & w_mask) == w_mask;

  assign w_a       = r_mem[w_j];
  assign w_b       = r_mem[w_jl];
  assign w_zeta    = i_zetas[{r_k, 4'b0000} +: 12];
  assign w_sum     = {1'b0, w_a} + {1'b0, w_b};
  assign w_sum_red = (w_sum >= 13'(Q)) ? 12'(w_sum - 13'(Q)) : w_sum[11:0];
  assign w_diff    = {1'b0, w_b} + 13'(Q) - {1'b0, w_a};
  assign w_bf_prod = 26'(w_zeta) * 26'(w_diff);
  assign w_bf_red  = f_reduce(w_bf_prod);

  // Prefetch the next coefficient so a handshake can be followed by new data at once.
  assign w_oaddr    = r_out_valid ? (r_idx + 8'd1) : r_idx;
  assign w_out_prod = 26'(r_mem[w_oaddr]) * 26'(N_INV);
  assign w_out_red  = f_reduce(w_out_prod);

  logic [127:0] w_zeta_hi_unused;
  logic         w_in_hi_unused;
  for (genvar gi = 0; gi < 128; gi++) begin : g_zeta_hi
    assign w_zeta_hi_unused[gi] = |i_zetas[16*gi+12 +: 4];
  end
  assign w_in_hi_unused = |i_in_data[15:12];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:    if (w_load_xfer && (r_idx == c_LAST_IDX)) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (w_cmp_last) w_state_nxt = S_OUT;
      S_OUT:     if (w_out_xfer && (r_idx == c_LAST_IDX)) w_state_nxt = S_LOAD;
      default:   w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_load_xfer) begin
        r_mem[r_idx] <= i_in_data[11:0];
      end else if (r_state == S_COMPUTE) begin
        r_mem[w_j]  <= w_sum_red;
        r_mem[w_jl] <= w_bf_red;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= 8'd0;
      r_bf        <= 7'd0;
      r_layer     <= 3'd0;
      r_k         <= 7'd0;
      r_out_data  <= 12'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_load_xfer) begin
            r_idx   <= r_idx + 8'd1;
            r_bf    <= 7'd0;
            r_layer <= 3'd0;
            r_k     <= 7'd127;
          end
        end
        S_COMPUTE: begin
          r_bf <= r_bf + 7'd1;
          if (r_bf == 7'd127) r_layer <= r_layer + 3'd1;
          if (w_blk_end)      r_k     <= r_k - 7'd1;
        end
        S_OUT: begin
          if (!r_out_valid) begin
            r_out_data  <= w_out_red;
            r_out_valid <= 1'b1;
          end else if (i_out_ready) begin
            r_idx <= r_idx + 8'd1;
            if (r_idx == c_LAST_IDX) r_out_valid <= 1'b0;
            else                     r_out_data  <= w_out_red;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_LOAD);
  assign o_busy      = (r_state == S_COMPUTE);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = {4'b0000, r_out_data};

endmodule

`default_nettype wire

// File: tb/tb_intt_core.sv
//------------------------------------------------------------------------------
// tb_intt_core : scoreboard bench for intt_core against a FIPS-203 style INTT model.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_intt_core;
  localparam int Q = 3329;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2047:0] zetas;
  logic [15:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  intt_core dut (
    .clk(clk), .rst(rst), .i_zetas(zetas),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int zeta_tb [128];
  int frame_in [256];
  int sb [$];
  int chk = 0;
  int err = 0;
  int cyc = 0;
  int last_xfer_cyc = 0;
  bit lat_armed = 0;
  int hs_count = 0;
  int ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int brv7(input int x);
    int r = 0;
    for (int b = 0; b < 7; b++) r = r | (((x >> b) & 1) << (6 - b));
    return r;
  endfunction

  function automatic int pow17(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = (p * 17) % Q;
    return p;
  endfunction

  // Reference: textbook inverse NTT over a plain array, then scale by 128^-1.
  task automatic push_model();
    int f [256];
    int k = 127;
    int z, t;
    for (int i = 0; i < 256; i++) f[i] = frame_in[i];
    for (int len = 2; len <= 128; len = len * 2) begin
      for (int s = 0; s < 256; s += 2 * len) begin
        z = zeta_tb[k];
        k--;
        for (int j = s; j < s + len; j++) begin
          t          = f[j];
          f[j]       = (t + f[j+len]) % Q;
          f[j+len]   = (z * (f[j+len] - t + Q)) % Q;
        end
      end
    end
    for (int i = 0; i < 256; i++) sb.push_back((f[i] * 3303) % Q);
  endtask

  task automatic push_const(input int c);
    sb.push_back(c);
    for (int i = 1; i < 256; i++) sb.push_back(0);
  endtask

  task automatic fill_const(input int c);
    for (int i = 0; i < 256; i++) frame_in[i] = (i % 2 == 0) ? c : 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) frame_in[i] = int'($urandom_range(0, Q - 1));
  endtask

  task automatic load_frame(input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom_range(0, Q - 1));
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = 16'(frame_in[i]);
      n = 0;
      while (!in_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        chk++;
        err++;
        $display("FAIL load_timeout: in_ready got 0 expected 1");
      end
      if (i == 255) begin
        last_xfer_cyc = cyc;
        lat_armed     = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid || !in_ready) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk++;
    if (n >= 6000) begin
      err++;
      $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_frame(input bit garbage);
    int h0 = hs_count;
    load_frame(256);
    check("busy_after_load", 32'(busy), 1);
    check("in_ready_in_compute", 32'(in_ready), 0);
    if (garbage) begin
      in_valid = 1'b1;
      repeat (300) begin
        in_data = 16'($urandom_range(0, Q - 1));
        @(negedge clk);
      end
      in_valid = 1'b0;
    end
    wait_drain();
    check("handshakes", 32'(hs_count - h0), 256);
  endtask

  initial begin
    int pc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (pc % 3 == 0);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      pc++;
    end
  end

  // Monitor: pops the scoreboard on each output handshake.
  initial begin
    bit          prev_hold = 0;
    logic [15:0] prev_data = 16'd0;
    int          e;
    forever begin
      @(negedge clk);
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (lat_armed && out_valid) begin
        check("latency", 32'(cyc - last_xfer_cyc), 898);
        lat_armed = 1'b0;
      end
      if (out_valid) check("in_ready_while_draining", 32'(in_ready), 0);
      if (out_valid && out_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          chk++;
          err++;
          $display("FAIL unexpected_output: got %0d expected none", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  initial begin
    #2_000_000;
    err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      zeta_tb[i] = pow17(brv7(i));
      zetas[16*i +: 16] = 16'(zeta_tb[i]);
    end
    in_valid = 1'b0;
    in_data  = 16'd0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    fill_const(0); push_const(0); run_frame(1'b0);
    fill_const(1); push_const(1); run_frame(1'b1);

    // Partial frame aborted by reset must leave no trace.
    fill_random(); load_frame(100);
    rst = 1'b1;
    @(negedge clk);
    check("midload_rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    fill_const(5); push_const(5); run_frame(1'b0);
    fill_const(1); push_const(1); run_frame(1'b0);

    ready_mode = 0; fill_random(); push_model(); run_frame(1'b0);
    ready_mode = 1; push_model(); run_frame(1'b0);
    ready_mode = 2; fill_random(); push_model(); run_frame(1'b1);
    ready_mode = 0;

    // Abort at compute cycle 400.
    fill_random(); load_frame(256);
    lat_armed = 1'b0;
    repeat (399) @(negedge clk);
    check("busy_mid_compute", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    fill_const(1); push_const(1); run_frame(1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

`default_nettype wire
